// File: rtl/switch_allocator_if.sv
// Router switch-allocator bundle: per-input requests, per-output readiness,
// grants back to the inputs and the crossbar select lines.
interface switch_allocator_if;
  logic [4:0]  req;
  logic [14:0] dst;
  logic [4:0]  tail;
  logic [4:0]  out_ready;
  logic [4:0]  grant;
  logic [2:0]  Select_L;
  logic [2:0]  Select_N;
  logic [2:0]  Select_E;
  logic [2:0]  Select_W;
  logic [2:0]  Select_S;

  // Router input side: drives requests and sees grants and selects.
  modport master (
    output req, dst, tail, out_ready,
    input  grant, Select_L, Select_N, Select_E, Select_W, Select_S
  );

  // Allocator side.
  modport slave (
    input  req, dst, tail, out_ready,
    output grant, Select_L, Select_N, Select_E, Select_W, Select_S
  );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator for a 5-port router (L,N,E,W,S).
// Each output locks to one input from head flit to tail flit.
module switch_allocator #(
  parameter int NPORT    = 5,
  parameter int SEL_W    = 3,
  parameter int SEL_IDLE = 5
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);

  localparam logic [SEL_W-1:0] IDLE_CODE = SEL_W'(SEL_IDLE);
  localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(NPORT - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           state_q [NPORT];
  state_t           state_d [NPORT];
  logic [SEL_W-1:0] owner_q [NPORT];
  logic [SEL_W-1:0] owner_d [NPORT];
  logic [SEL_W-1:0] ptr_q   [NPORT];
  logic [SEL_W-1:0] ptr_d   [NPORT];
  logic [SEL_W:0]   pick    [NPORT];
  logic [NPORT-1:0] cand    [NPORT];
  logic [SEL_W-1:0] dst_i   [NPORT];
  logic [SEL_W-1:0] sel     [NPORT];
  logic [NPORT-1:0] grant_c;

  // Returns {found, winner}: first set bit of cand scanning ptr+1, ptr+2, ... mod NPORT.
  function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0] ptr,
                                             input logic [NPORT-1:0] c);
    logic [SEL_W:0]   r;
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    r = '0;
    // Scan from farthest to nearest so the nearest candidate overwrites last.
    for (int k = NPORT; k >= 1; k--) begin
      sum = {1'b0, ptr} + (SEL_W + 1)'(k);
      if (sum >= (SEL_W + 1)'(NPORT)) sum = sum - (SEL_W + 1)'(NPORT);
      idx = sum[SEL_W-1:0];
      if (c[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // Codes 5..7 never equal an output index, so they never become candidates.
  always_comb begin
    for (int i = 0; i < NPORT; i++) dst_i[i] = bus.dst[SEL_W*i +: SEL_W];
    for (int o = 0; o < NPORT; o++)
      for (int i = 0; i < NPORT; i++)
        cand[o][i] = bus.req[i] && (dst_i[i] == SEL_W'(o));
  end

  // NOTE: reset is synchronous here, so lock state is only cleared at an edge;
  // grant is additionally masked by rst below so nothing transfers in the reset cycle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every output
    // samples the same pre-edge values regardless of evaluation order.
    if (rst) begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= LAST_PORT;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    grant_c = '0;
    for (int o = 0; o < NPORT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      pick[o]    = rr_pick(ptr_q[o], cand[o]);
      case (state_q[o])
        ST_IDLE: begin
          if (pick[o][SEL_W]) begin
            state_d[o] = ST_LOCKED;
            owner_d[o] = pick[o][SEL_W-1:0];
            ptr_d[o]   = pick[o][SEL_W-1:0];
          end
        end
        ST_LOCKED: begin
          for (int i = 0; i < NPORT; i++) begin
            if (owner_q[o] == SEL_W'(i) && cand[o][i] && bus.out_ready[o]) begin
              grant_c[i] = 1'b1;
              if (bus.tail[i]) state_d[o] = ST_IDLE;
            end
          end
        end
        default: state_d[o] = ST_IDLE;
      endcase
    end
  end

  // Selects depend only on registered state, so they move only at clock edges.
  always_comb begin
    for (int o = 0; o < NPORT; o++)
      sel[o] = (state_q[o] == ST_LOCKED) ? owner_q[o] : IDLE_CODE;
  end

  assign bus.grant    = rst ? '0 : grant_c;
  assign bus.Select_L = sel[0];
  assign bus.Select_N = sel[1];
  assign bus.Select_E = sel[2];
  assign bus.Select_W = sel[3];
  assign bus.Select_S = sel[4];

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: a table of per-cycle vectors plus a
// hand-written reset-mid-packet sequence, compared through an expectation queue.
module tb_switch_allocator;

  typedef struct {
    logic        rst;
    logic [4:0]  req;
    logic [14:0] dst;
    logic [4:0]  tail;
    logic [4:0]  rdy;
    logic [4:0]  exp_grant;
    logic [14:0] exp_sel;
    int          tid;
  } vec_t;

  typedef struct packed {
    logic [4:0]  grant;
    logic [14:0] sel;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  vec_t vecs[$];
  exp_t sb[$];

  switch_allocator_if bus();

  switch_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs five 3-bit codes, L in the low bits; used for dst and for selects.
  function automatic logic [14:0] p5(input int l, input int n, input int e,
                                     input int w, input int s);
    return {3'(s), 3'(w), 3'(e), 3'(n), 3'(l)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [4:0] rq, input logic [14:0] d,
                     input logic [4:0] tl, input logic [4:0] rd,
                     input logic [4:0] eg, input logic [14:0] es, input int tid);
    vec_t v;
    v.rst = r; v.req = rq; v.dst = d; v.tail = tl; v.rdy = rd;
    v.exp_grant = eg; v.exp_sel = es; v.tid = tid;
    vecs.push_back(v);
  endtask

  // One cycle: drive at the falling edge, queue the expectation, sample mid-low-phase.
  task automatic step(input logic r, input logic [4:0] rq, input logic [14:0] d,
                      input logic [4:0] tl, input logic [4:0] rd,
                      input logic [4:0] eg, input logic [14:0] es, input int tid);
    exp_t        e;
    logic [14:0] act_sel;
    @(negedge clk);
    rst           = r;
    bus.req       = rq;
    bus.dst       = d;
    bus.tail      = tl;
    bus.out_ready = rd;
    sb.push_back('{grant: eg, sel: es});
    #2;
    e = sb.pop_front();
    act_sel = {bus.Select_S, bus.Select_W, bus.Select_E, bus.Select_N, bus.Select_L};
    check($sformatf("t%0d.%0d grant", tid, step_no), {27'b0, bus.grant}, {27'b0, e.grant});
    check($sformatf("t%0d.%0d select", tid, step_no), {17'b0, act_sel}, {17'b0, e.sel});
    step_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] si, d2, d3, d4, dp, sn0;
    si  = p5(5, 5, 5, 5, 5);
    d2  = p5(2, 5, 5, 5, 5);
    d3  = p5(5, 2, 5, 2, 2);
    d4  = p5(1, 5, 1, 5, 5);
    dp  = p5(1, 2, 3, 4, 0);
    sn0 = p5(5, 0, 5, 5, 5);

    // Reset with all inputs requesting: nothing granted, all selects idle.
    add(1, 5'h1F, p5(2, 2, 2, 2, 2), 5'h1F, 5'h1F, 5'h00, si, 1);
    add(1, 5'h1F, p5(2, 2, 2, 2, 2), 5'h1F, 5'h1F, 5'h00, si, 1);
    // L -> E single flit: lock after one edge, release after the tail.
    add(0, 5'h01, d2, 5'h01, 5'h1F, 5'h00, si, 2);
    add(0, 5'h01, d2, 5'h01, 5'h1F, 5'h01, p5(5, 5, 0, 5, 5), 2);
    add(0, 5'h00, d2, 5'h01, 5'h1F, 5'h00, si, 2);
    // N, W, S all to E; N re-requests after its grant and must wait for S.
    add(0, 5'h1A, d3, 5'h1F, 5'h1F, 5'h00, si, 3);
    add(0, 5'h1A, d3, 5'h1F, 5'h1F, 5'h02, p5(5, 5, 1, 5, 5), 3);
    add(0, 5'h18, d3, 5'h1F, 5'h1F, 5'h00, si, 3);
    add(0, 5'h18, d3, 5'h1F, 5'h1F, 5'h08, p5(5, 5, 3, 5, 5), 3);
    add(0, 5'h12, d3, 5'h1F, 5'h1F, 5'h00, si, 3);
    add(0, 5'h12, d3, 5'h1F, 5'h1F, 5'h10, p5(5, 5, 4, 5, 5), 3);
    add(0, 5'h02, d3, 5'h1F, 5'h1F, 5'h00, si, 3);
    add(0, 5'h02, d3, 5'h1F, 5'h1F, 5'h02, p5(5, 5, 1, 5, 5), 3);
    add(0, 5'h00, d3, 5'h1F, 5'h1F, 5'h00, si, 3);
    // L 3-flit packet to N with a one-cycle stall; E waits for tail + idle cycle.
    add(0, 5'h01, d4, 5'h04, 5'h1F, 5'h00, si, 4);
    add(0, 5'h05, d4, 5'h04, 5'h1F, 5'h01, sn0, 4);
    add(0, 5'h05, d4, 5'h04, 5'h1D, 5'h00, sn0, 4);
    add(0, 5'h05, d4, 5'h04, 5'h1F, 5'h01, sn0, 4);
    add(0, 5'h05, d4, 5'h05, 5'h1F, 5'h01, sn0, 4);
    add(0, 5'h04, d4, 5'h04, 5'h1F, 5'h00, si, 4);
    add(0, 5'h04, d4, 5'h04, 5'h1F, 5'h04, p5(5, 2, 5, 5, 5), 4);
    add(0, 5'h00, d4, 5'h04, 5'h1F, 5'h00, si, 4);
    // Full permutation: every output locks on the same edge.
    add(0, 5'h1F, dp, 5'h1F, 5'h1F, 5'h00, si, 5);
    add(0, 5'h1F, dp, 5'h1F, 5'h1F, 5'h1F, p5(4, 0, 1, 2, 3), 5);
    add(0, 5'h00, dp, 5'h1F, 5'h1F, 5'h00, si, 5);
    // U-turn L -> L is legal.
    add(0, 5'h01, p5(0, 5, 5, 5, 5), 5'h01, 5'h1F, 5'h00, si, 7);
    add(0, 5'h01, p5(0, 5, 5, 5, 5), 5'h01, 5'h1F, 5'h01, p5(0, 5, 5, 5, 5), 7);
    add(0, 5'h00, p5(0, 5, 5, 5, 5), 5'h01, 5'h1F, 5'h00, si, 7);
    // Destination codes 5..7 are never arbitrated or granted.
    add(0, 5'h1F, p5(7, 6, 5, 7, 6), 5'h1F, 5'h1F, 5'h00, si, 8);
    add(0, 5'h1F, p5(7, 6, 5, 7, 6), 5'h1F, 5'h1F, 5'h00, si, 8);

    rst           = 1'b1;
    bus.req       = '0;
    bus.dst       = '0;
    bus.tail      = '0;
    bus.out_ready = '0;
    repeat (2) @(posedge clk);

    foreach (vecs[n])
      step(vecs[n].rst, vecs[n].req, vecs[n].dst, vecs[n].tail, vecs[n].rdy,
           vecs[n].exp_grant, vecs[n].exp_sel, vecs[n].tid);

    // Reset mid-packet: lock dropped, no grant in the reset cycle, and the
    // pointer returns to L-first so L beats E on the following contention.
    step(0, 5'h01, d4, 5'h00, 5'h1F, 5'h00, si, 6);
    step(0, 5'h05, d4, 5'h04, 5'h1F, 5'h01, sn0, 6);
    step(1, 5'h05, d4, 5'h04, 5'h1F, 5'h00, sn0, 6);
    step(0, 5'h05, d4, 5'h04, 5'h1F, 5'h00, si, 6);
    step(0, 5'h05, d4, 5'h04, 5'h1F, 5'h01, sn0, 6);
    step(0, 5'h05, d4, 5'h05, 5'h1F, 5'h01, sn0, 6);
    step(0, 5'h04, d4, 5'h04, 5'h1F, 5'h00, si, 6);
    step(0, 5'h04, d4, 5'h04, 5'h1F, 5'h04, p5(5, 2, 5, 5, 5), 6);
    step(0, 5'h00, d4, 5'h04, 5'h1F, 5'h00, si, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
